reduceron_gc_sched: RTL and testbench

- Sequences garbage collection for the Reduceron core and arbitrates its single heap memory port between the reducer (mutator) and the collector.
- Watches the heap pointer and requests GC when the heap crosses a limit. Stalls the reducer at an instruction boundary, hands the port to the collector, and resumes the reducer afterwards.
- Sits between the reducer, the collector and the heap RAM. Drives the GC bit of the exported state vector (state bit 5) through gc_active.

---
 rtl/reduceron_pkg.sv | 23 ++
 rtl/reduceron_heap_port_mux.sv | 51 +++++
 rtl/reduceron_gc_sched.sv | 164 ++++++++++++++++
 tb/tb_reduceron_gc_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduceron_pkg.sv
// Shared definitions for the Reduceron garbage-collection scheduler slice:
// sequencer state encoding, default widths and exported state-vector layout.
package reduceron_pkg;

  localparam int HEAP_AW_DEFAULT = 13;
  localparam int DATA_W_DEFAULT  = 16;

  // Position of the GC flag in the core's exported state vector.
  localparam int STATE_GC_BIT = 5;

  // Heap words carry a type tag in their low bits.
  localparam int TAG_W = 3;

  // Collector sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_RESUME  = 3'd3,
    ST_FULL    = 3'd4
  } gc_state_e;

endpackage

// File: rtl/reduceron_heap_port_mux.sv
// Heap RAM port arbitration: grants and mem_* selection keyed on the GC state.
// The mutator owns the port while running or draining, the collector while
// collecting, and the port is parked at zero otherwise.
module reduceron_heap_port_mux
  import reduceron_pkg::*;
#(
  parameter int HEAP_AW = HEAP_AW_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT
) (
  input  gc_state_e           state,
  input  logic                mut_req,
  input  logic                mut_we,
  input  logic [HEAP_AW-1:0]  mut_addr,
  input  logic [DATA_W-1:0]   mut_wdata,
  input  logic                gc_req,
  input  logic                gc_we,
  input  logic [HEAP_AW-1:0]  gc_addr,
  input  logic [DATA_W-1:0]   gc_wdata,
  output logic                mut_gnt,
  output logic                gc_gnt,
  output logic [HEAP_AW-1:0]  mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata
);

  // Select the port owner; writes only reach the RAM when the access is granted.
  always_comb begin
    mut_gnt   = 1'b0;
    gc_gnt    = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      ST_IDLE, ST_DRAIN: begin
        mut_gnt   = mut_req;
        mem_addr  = mut_addr;
        mem_we    = mut_we & mut_req;
        mem_wdata = mut_wdata;
      end
      ST_COLLECT: begin
        gc_gnt    = gc_req;
        mem_addr  = gc_addr;
        mem_we    = gc_we & gc_req;
        mem_wdata = gc_wdata;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/reduceron_gc_sched.sv
// Reduceron GC scheduler: watches the heap pointer, stalls the reducer at an
// instruction boundary, hands the heap port to the collector, then reloads
// the heap pointer and resumes (or parks in FULL if too little was freed).
// Optional build macro REDUCERON_GC_STATS_EN adds gc_count / gc_cycles.
module reduceron_gc_sched
  import reduceron_pkg::*;
#(
  parameter int HEAP_AW    = HEAP_AW_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int HEAP_LIMIT = 7680
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [HEAP_AW-1:0]  hp,
  input  logic                mut_busy,
  input  logic                gc_force,
  input  logic                mut_req,
  input  logic                mut_we,
  input  logic [HEAP_AW-1:0]  mut_addr,
  input  logic [DATA_W-1:0]   mut_wdata,
  output logic                mut_gnt,
  output logic                mut_stall,
  input  logic                gc_req,
  input  logic                gc_we,
  input  logic [HEAP_AW-1:0]  gc_addr,
  input  logic [DATA_W-1:0]   gc_wdata,
  output logic                gc_gnt,
  output logic                gc_start,
  input  logic                gc_done,
  input  logic [HEAP_AW-1:0]  gc_hp,
  output logic                hp_load,
  output logic [HEAP_AW-1:0]  hp_new,
  output logic                gc_active,
  output logic                heap_full,
  output logic [HEAP_AW-1:0]  mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata
`ifdef REDUCERON_GC_STATS_EN
  ,
  output logic [15:0]         gc_count,
  output logic [31:0]         gc_cycles
`endif
);

  localparam logic [HEAP_AW-1:0] LIMIT = HEAP_AW'(HEAP_LIMIT);

  gc_state_e          state;
  gc_state_e          state_nxt;
  logic               trig;
  logic               pend;
  logic               enter_collect;
  logic [HEAP_AW-1:0] gc_hp_lat;

  assign enter_collect = (state != ST_COLLECT) && (state_nxt == ST_COLLECT);

  // State register; reset returns to IDLE from anywhere, even mid-collection.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Registered heap-limit compare and gc_force latch (consumed on COLLECT entry).
  always_ff @(posedge clock) begin
    if (reset) begin
      trig <= 1'b0;
      pend <= 1'b0;
    end else begin
      trig <= (hp >= LIMIT);
      if (enter_collect)
        pend <= 1'b0;
      else if ((state != ST_COLLECT) && gc_force)
        pend <= 1'b1;
    end
  end

  // Capture the post-GC heap pointer reported alongside gc_done.
  always_ff @(posedge clock) begin
    if ((state == ST_COLLECT) && gc_done)
      gc_hp_lat <= gc_hp;
  end

  // Next-state decode and per-state control outputs.
  always_comb begin
    state_nxt = state;
    mut_stall = 1'b0;
    gc_start  = 1'b0;
    hp_load   = 1'b0;
    hp_new    = '0;
    gc_active = 1'b0;
    heap_full = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig || pend || gc_force)
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Wait for the reducer to reach an instruction boundary.
        mut_stall = 1'b1;
        if (!mut_busy) begin
          gc_start  = 1'b1;
          gc_active = 1'b1;
          state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        mut_stall = 1'b1;
        gc_active = 1'b1;
        if (gc_done)
          state_nxt = ST_RESUME;
      end
      ST_RESUME: begin
        mut_stall = 1'b1;
        gc_active = 1'b1;
        hp_load   = 1'b1;
        hp_new    = gc_hp_lat;
        // Still over the limit after collecting: the heap is genuinely full.
        state_nxt = (gc_hp_lat >= LIMIT) ? ST_FULL : ST_IDLE;
      end
      ST_FULL: begin
        mut_stall = 1'b1;
        heap_full = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  reduceron_heap_port_mux #(
    .HEAP_AW (HEAP_AW),
    .DATA_W  (DATA_W)
  ) u_port_mux (
    .state     (state),
    .mut_req   (mut_req),
    .mut_we    (mut_we),
    .mut_addr  (mut_addr),
    .mut_wdata (mut_wdata),
    .gc_req    (gc_req),
    .gc_we     (gc_we),
    .gc_addr   (gc_addr),
    .gc_wdata  (gc_wdata),
    .mut_gnt   (mut_gnt),
    .gc_gnt    (gc_gnt),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

`ifdef REDUCERON_GC_STATS_EN
  // Collection statistics: saturating start count, wrapping active-cycle count.
  always_ff @(posedge clock) begin
    if (reset) begin
      gc_count  <= '0;
      gc_cycles <= '0;
    end else begin
      if (gc_start && (gc_count != 16'hFFFF))
        gc_count <= gc_count + 16'd1;
      if (gc_active)
        gc_cycles <= gc_cycles + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_reduceron_gc_sched.sv
// Self-checking bench for reduceron_gc_sched: directed GC scenarios followed by
// randomized traffic, checked every cycle against a behavioural model through
// an expected-output queue drained by an independent monitor.
`timescale 1ns/1ps
module tb_reduceron_gc_sched;

  localparam int AW = 13;
  localparam int DW = 16;
  localparam logic [AW-1:0] LIMIT = 13'd7680;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset = 1'b1;
  logic [AW-1:0] hp = '0;
  logic          mut_busy = 1'b0, gc_force = 1'b0;
  logic          mut_req = 1'b0, mut_we = 1'b0;
  logic [AW-1:0] mut_addr = '0;
  logic [DW-1:0] mut_wdata = '0;
  logic          gc_req = 1'b0, gc_we = 1'b0;
  logic [AW-1:0] gc_addr = '0;
  logic [DW-1:0] gc_wdata = '0;
  logic          gc_done = 1'b0;
  logic [AW-1:0] gc_hp = '0;

  logic          mut_gnt, mut_stall, gc_gnt, gc_start, hp_load, gc_active, heap_full, mem_we;
  logic [AW-1:0] hp_new, mem_addr;
  logic [DW-1:0] mem_wdata;
`ifdef REDUCERON_GC_STATS_EN
  logic [15:0]   gc_count;
  logic [31:0]   gc_cycles;
`endif

  reduceron_gc_sched #(.HEAP_AW(AW), .DATA_W(DW), .HEAP_LIMIT(7680)) dut (
    .clock(clock), .reset(reset), .hp(hp), .mut_busy(mut_busy), .gc_force(gc_force),
    .mut_req(mut_req), .mut_we(mut_we), .mut_addr(mut_addr), .mut_wdata(mut_wdata),
    .mut_gnt(mut_gnt), .mut_stall(mut_stall),
    .gc_req(gc_req), .gc_we(gc_we), .gc_addr(gc_addr), .gc_wdata(gc_wdata),
    .gc_gnt(gc_gnt), .gc_start(gc_start), .gc_done(gc_done), .gc_hp(gc_hp),
    .hp_load(hp_load), .hp_new(hp_new), .gc_active(gc_active), .heap_full(heap_full),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata)
`ifdef REDUCERON_GC_STATS_EN
    , .gc_count(gc_count), .gc_cycles(gc_cycles)
`endif
  );

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] hp;
    logic          busy, frc, mreq, mwe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwd;
    logic          greq, gwe;
    logic [AW-1:0] gaddr;
    logic [DW-1:0] gwd;
    logic          done;
    logic [AW-1:0] ghp;
  } stim_t;

  typedef struct packed {
    logic          mut_gnt, mut_stall, gc_gnt, gc_start, hp_load, gc_active, heap_full, mem_we;
    logic [AW-1:0] hp_new, mem_addr;
    logic [DW-1:0] mem_wdata;
`ifdef REDUCERON_GC_STATS_EN
    logic [15:0]   gc_count;
    logic [31:0]   gc_cycles;
`endif
  } obs_t;

  typedef struct packed {
    logic chk;
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle_no = 0;
  bit   started = 0;
  stim_t s;

  // Behavioural model: what the scheduler is doing, in plain words.
  string         mode = "run";   // run, drain, gc, resume, full
  bit            over_last = 0;  // heap pointer was at/over the limit last cycle
  bit            force_seen = 0; // an unserved gc_force is outstanding
  logic [AW-1:0] saved_hp = '0;
  int            starts = 0;
  longint        active_cycles = 0;

  function automatic obs_t model_out(input stim_t t);
    obs_t o;
    o = '0;
    if (mode == "run" || mode == "drain") begin
      o.mut_gnt   = t.mreq;
      o.mem_addr  = t.maddr;
      o.mem_wdata = t.mwd;
      o.mem_we    = t.mwe && t.mreq;
    end
    if (mode == "gc") begin
      o.gc_gnt    = t.greq;
      o.mem_addr  = t.gaddr;
      o.mem_wdata = t.gwd;
      o.mem_we    = t.gwe && t.greq;
    end
    o.mut_stall = (mode != "run");
    o.gc_start  = (mode == "drain") && !t.busy;
    o.gc_active = o.gc_start || mode == "gc" || mode == "resume";
    o.hp_load   = (mode == "resume");
    o.hp_new    = (mode == "resume") ? saved_hp : '0;
    o.heap_full = (mode == "full");
`ifdef REDUCERON_GC_STATS_EN
    o.gc_count  = 16'(starts);
    o.gc_cycles = 32'(active_cycles);
`endif
    return o;
  endfunction

  task automatic model_advance(input stim_t t, input obs_t o);
    string nxt;
    if (t.rst) begin
      mode = "run"; over_last = 0; force_seen = 0; starts = 0; active_cycles = 0;
      return;
    end
    if (o.gc_start && starts < 65535) starts++;
    if (o.gc_active) active_cycles = (active_cycles + 1) % 64'h1_0000_0000;
    nxt = mode;
    if (mode == "run" && (over_last || force_seen || t.frc)) nxt = "drain";
    else if (mode == "drain" && !t.busy) nxt = "gc";
    else if (mode == "gc" && t.done) begin nxt = "resume"; saved_hp = t.ghp; end
    else if (mode == "resume") nxt = (saved_hp >= LIMIT) ? "full" : "run";
    if (mode != "gc" && nxt == "gc") force_seen = 0;
    else if (mode != "gc" && t.frc) force_seen = 1;
    over_last = (t.hp >= LIMIT);
    mode = nxt;
  endtask

  // Apply one cycle of stimulus, queue its expected response, advance the model.
  task automatic step();
    exp_t e;
    reset = s.rst; hp = s.hp; mut_busy = s.busy; gc_force = s.frc;
    mut_req = s.mreq; mut_we = s.mwe; mut_addr = s.maddr; mut_wdata = s.mwd;
    gc_req = s.greq; gc_we = s.gwe; gc_addr = s.gaddr; gc_wdata = s.gwd;
    gc_done = s.done; gc_hp = s.ghp;
    e.o = model_out(s);
    e.chk = started;
    e.cyc = cycle_no;
    expq.push_back(e);
    model_advance(s, e.o);
    started = 1;
    cycle_no++;
    @(posedge clock); #1;
  endtask

  task automatic rand_traffic();
    s.mreq = 1'($urandom); s.mwe = 1'($urandom);
    s.maddr = AW'($urandom); s.mwd = DW'($urandom);
    s.greq = 1'($urandom); s.gwe = 1'($urandom);
    s.gaddr = AW'($urandom); s.gwd = DW'($urandom);
  endtask

  task automatic run_until(input string m, input int bound);
    int n;
    n = 0;
    while (mode != m && n < bound) begin rand_traffic(); step(); n++; end
    if (mode != m) begin
      vectors++; miscompares++;
      $display("FAIL reach_%s: model still in %s after %0d cycles, required %s", m, mode, bound, m);
    end
  endtask

  // One collection: run to gc, collect a few cycles, finish with the given pointer.
  task automatic collect(input logic [AW-1:0] new_hp, input int gc_len);
    run_until("gc", 20);
    for (int i = 0; i < gc_len; i++) begin rand_traffic(); step(); end
    s.done = 1'b1; s.ghp = new_hp; rand_traffic(); step();
    s.done = 1'b0; rand_traffic(); step();          // resume cycle
  endtask

  function automatic string show(input obs_t o);
    return $sformatf("gnt=%b stall=%b ggnt=%b start=%b load=%b hpn=%0d act=%b full=%b we=%b addr=%0d wd=%h",
                     o.mut_gnt, o.mut_stall, o.gc_gnt, o.gc_start, o.hp_load, o.hp_new,
                     o.gc_active, o.heap_full, o.mem_we, o.mem_addr, o.mem_wdata);
  endfunction

  // Monitor: compare DUT outputs against the queued expectation, mid-cycle.
  initial begin
    exp_t  e;
    obs_t  a;
    forever begin
      @(negedge clock);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        if (e.chk) begin
          a = '0;
          a.mut_gnt = mut_gnt; a.mut_stall = mut_stall; a.gc_gnt = gc_gnt; a.gc_start = gc_start;
          a.hp_load = hp_load; a.gc_active = gc_active; a.heap_full = heap_full; a.mem_we = mem_we;
          a.hp_new = hp_new; a.mem_addr = mem_addr; a.mem_wdata = mem_wdata;
`ifdef REDUCERON_GC_STATS_EN
          a.gc_count = gc_count; a.gc_cycles = gc_cycles;
`endif
          vectors++;
          if (a !== e.o) begin
            miscompares++;
            $display("FAIL outputs cycle %0d: got {%s} required {%s}", e.cyc, show(a), show(e.o));
`ifdef REDUCERON_GC_STATS_EN
            $display("FAIL stats cycle %0d: got count=%0d cycles=%0d required count=%0d cycles=%0d",
                     e.cyc, a.gc_count, a.gc_cycles, e.o.gc_count, e.o.gc_cycles);
`endif
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int full_len;
    s = '0;
    @(posedge clock); #1;
    // Reset, then a quiet idle cycle.
    s.rst = 1'b1; step(); step();
    s.rst = 1'b0; step();

    // Heap pointer ramps to the limit with the reducer free.
    for (int h = 0; h <= 7680; h += 64) begin s.hp = AW'(h); rand_traffic(); step(); end
    collect(13'd100, 4);
    s.hp = 13'd100;
    for (int i = 0; i < 3; i++) begin rand_traffic(); step(); end

    // Forced GC while the reducer is busy: DRAIN must hold and keep granting.
    s.frc = 1'b1; s.busy = 1'b1; rand_traffic(); step();
    s.frc = 1'b0; s.mreq = 1'b1;
    for (int i = 0; i < 5; i++) begin s.mwe = 1'($urandom); s.maddr = AW'($urandom); step(); end
    s.busy = 1'b0;
    collect(13'd100, 3);
    for (int i = 0; i < 2; i++) begin rand_traffic(); step(); end

    // Collection frees too little: FULL is sticky until reset.
    s.frc = 1'b1; step(); s.frc = 1'b0;
    collect(13'd7800, 2);
    for (int i = 0; i < 5; i++) begin s.frc = 1'($urandom); rand_traffic(); step(); end
    s.frc = 1'b0;
    s.rst = 1'b1; step(); s.rst = 1'b0; s.mreq = 1'b0; step(); step();

    // Reset lands in the middle of a collection with the collector writing.
    s.frc = 1'b1; step(); s.frc = 1'b0;
    run_until("gc", 10);
    s.greq = 1'b1; s.gwe = 1'b1; s.mreq = 1'b0; step();
    s.rst = 1'b1; step();
    s.rst = 1'b0; s.greq = 1'b0; s.gwe = 1'b0; step(); step();

    // A single forced collection at a low heap pointer from a fresh reset.
    s.rst = 1'b1; step(); s.rst = 1'b0;
    s.hp = 13'd10; step();
    s.frc = 1'b1; step(); s.frc = 1'b0;
    collect(13'd10, 5);
    for (int i = 0; i < 3; i++) begin rand_traffic(); step(); end

    // Randomized operation.
    s.hp = '0; full_len = 0;
    for (int i = 0; i < 3000; i++) begin
      full_len = (mode == "full") ? full_len + 1 : 0;
      s.rst = (($urandom % 400) == 0) || (full_len > 8);
      if (mode == "resume") s.hp = saved_hp;
      else if (($urandom % 80) == 0) s.hp = AW'(7680 + ($urandom % 500));
      else if (s.hp < 13'd7700 && mode == "run") s.hp = s.hp + AW'($urandom % 40);
      s.busy = (($urandom % 3) == 0);
      s.frc  = (($urandom % 40) == 0);
      s.done = (($urandom % 6) == 0);
      s.ghp  = (($urandom % 7) == 0) ? AW'(7680 + ($urandom % 500)) : AW'($urandom % 7000);
      rand_traffic();
      step();
    end
    s = '0; step();

    repeat (3) @(negedge clock);
    if (expq.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
